// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the multi-cycle data-memory responder
//
// Purpose : FSM state encoding, data width, default latency and request op encoding
//           used by dmem_mc_responder and dmem_array.
// Ports   : none (package)

package dmem_pkg;

  localparam int DMEM_DATA_W      = 16;
  localparam int DMEM_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dmem_op_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word array with registered read data
//
// Purpose : backing storage for dmem_mc_responder; 2**ADDR_W words of DATA_W bits.
// Ports   : clk   in  clock, rising edge
//           we    in  write strobe, commits wdata to idx
//           re    in  read strobe, loads rdata from idx
//           idx   in  word index
//           wdata in  write data
//           rdata out registered read data, holds until the next re
// Storage and rdata carry no reset.

module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_mc_responder.sv
// rtl/dmem_mc_responder.sv - multi-cycle data-memory responder for the MEM stage
//
// Purpose : accepts one read or write at a time from IDLE, completes it LATENCY cycles
//           after acceptance, and pulses data_valid for one cycle on completion.
// Ports   : clk        in  clock, rising edge
//           rst_n      in  synchronous active-low reset
//           addr       in  byte address, word index = addr[ADDR_W:1]
//           data_in    in  write data, sampled at acceptance
//           wr         in  write request (wins over enable)
//           enable     in  read request
//           data_out   out read data, valid with data_valid, held until the next read completes
//           data_valid out one-cycle completion pulse
//           busy       out request in flight; new requests are ignored

module dmem_mc_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = DMEM_LATENCY_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            addr,
  input  logic [DMEM_DATA_W-1:0] data_in,
  input  logic                   wr,
  input  logic                   enable,
  output logic [DMEM_DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   busy
);

  dmem_state_e             r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_W-1:0]       r_idx;
  logic [DMEM_DATA_W-1:0]  r_wdata;
  dmem_op_e                r_op;
  // Set once a read has completed since reset; until then data_out reads as zero
  // because the array's read register has no reset of its own.
  logic                    r_rd_done;

  logic                    w_fire;
  logic                    w_we;
  logic                    w_re;
  logic [DMEM_DATA_W-1:0]  w_rdata;
  logic                    w_unused_addr;

  // The array access happens on the WAIT->RESP edge. Gating with rst_n makes a reset
  // on that same edge abort the access, so a pending write never commits.
  assign w_fire = rst_n && (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_we   = w_fire && (r_op == OP_WR);
  assign w_re   = w_fire && (r_op == OP_RD);

  assign w_unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DMEM_DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .re    (w_re),
    .idx   (r_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_op      <= OP_RD;
      r_rd_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wr || enable) begin
            r_idx   <= addr[ADDR_W:1];
            r_wdata <= data_in;
            r_op    <= wr ? OP_WR : OP_RD;
            // Acceptance edge plus the WAIT->RESP edge account for two of the LATENCY cycles.
            r_cnt   <= 4'(LATENCY - 2);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            if (r_op == OP_RD) begin
              r_rd_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The array read register only moves on a read completion, so it already holds
  // data_out between reads; writes leave it untouched.
  assign data_out   = r_rd_done ? w_rdata : '0;
  assign busy       = (r_state != ST_IDLE);
  assign data_valid = (r_state == ST_RESP);

endmodule
